seg_display_arbiter: RTL
========================

# seg_display_arbiter

Time-shares the 6-digit seven-segment display between three data sources and one priority alert source. Each slot holds the display for a fixed dwell time, and slots rotate round-robin among active requesters. The alert source preempts rotation. The block's registered 24-bit BCD output feeds the `data_in` of `seg_driver`, and its blank flag drives the driver's all-digits-off input.

## Interface
Parameters:
- `DWELL_CYC`, default 50_000_000: cycles each normal slot owns the display (1 s at 50 MHz); must be ≥ 2.
- `ALERT_MIN`, default 25_000_000: minimum cycles the alert stays displayed once granted; must be ≥ 1.

Ports:
- `clk`, in, 1: system clock, 50 MHz.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, 3: per-source display request, level.
- `data0`, in, 24: BCD digits of source 0 (6 × 4 bit, [23:20] = leftmost).
- `data1`, in, 24: BCD digits of source 1.
- `data2`, in, 24: BCD digits of source 2.
- `alert_req`, in, 1: priority request, level.
- `alert_data`, in, 24: BCD digits of the alert.
- `alert_ack`, out, 1: one-cycle pulse on the first cycle the alert is displayed.
- `data_out`, out, 24: registered digits to `seg_driver`.
- `blank`, out, 1: 1 = display off (no owner).
- `owner`, out, 2: 0/1/2 = normal source, 3 = alert; meaningless while `blank` = 1.
- `slot_start`, out, 1: one-cycle pulse on the first cycle of every new grant, including a re-grant to the same source.

## Operation
- States: IDLE, SHOW, ALERT.
- Reset (`rst` = 1 at a clock edge), all outputs and internals take these values:
  - state = IDLE, `data_out` = 0, `blank` = 1, `owner` = 0.
  - `alert_ack` = 0, `slot_start` = 0, dwell counter = 0, `last` (round-robin pointer) = 2.
  - Reset mid-slot or mid-alert aborts immediately; there is no resume.
- Priority: `alert_req` outranks everything in every state.
- IDLE:
  - If `alert_req`, go to ALERT.
  - Else, if any `req` bit is set, go to SHOW. The owner is the first set bit scanning `last`+1, `last`+2, `last`+3 (mod 3).
- SHOW (owner i):
  - The dwell counter counts 0 … DWELL_CYC−1.
  - At terminal count, rotate to the next requester after i by the same scan with `last` = i. This may re-grant i if i is the only requester.
  - If no source is requesting at terminal count, go to IDLE.
  - If `req[i]` drops before terminal count, rotate at the next edge; the slot is not completed.
  - `alert_req` = 1: go to ALERT and save the interrupted index i.
- ALERT:
  - `owner` = 3 and `data_out` follows `alert_data`.
  - The alert counter counts from 0. The state is left only when the counter ≥ ALERT_MIN−1 and `alert_req` = 0.
  - On exit:
    - If the interrupted source still requests, it is re-granted with its dwell restarted.
    - Else rotate from the interrupted index.
    - If no source is requesting, go to IDLE.
    - If the alert arrived from IDLE, scan from `last`.
- `data_out` is a registered mux of the current owner's data. It tracks live changes to that source's data with 1-cycle latency; it does not latch at grant.
- Counter widths: $clog2(DWELL_CYC) and $clog2(ALERT_MIN) bits, saturating. No wrap-around is permitted in ALERT.

## Timing
- Grant latency: 1 cycle. A request seen at edge N produces `owner`, `blank` = 0, `data_out` and `slot_start` valid after edge N+1.
- A normal slot lasts exactly DWELL_CYC cycles, measured from its `slot_start`, when uninterrupted.
- `alert_ack` and `slot_start` are both asserted on the first alert cycle.
- Simultaneous events at the same edge:
  - `alert_req` together with terminal count: alert wins, and the interrupted index is the expiring owner.
  - `req[i]` drop together with terminal count: normal rotation.
- A single-cycle `alert_req` pulse still yields exactly ALERT_MIN alert cycles.

## Test plan
Bench parameters: `DWELL_CYC` = 8, `ALERT_MIN` = 4, with data0 = 24'h111111, data1 = 24'h222222, data2 = 24'h333333, alert_data = 24'h999999.

- **Reset:** `rst` = 1 for 3 cycles with all `req` = 3'b111 → `blank` = 1 and `data_out` = 0 throughout. After release, owner 0 with `data_out` = 24'h111111 and `slot_start` one cycle later.
- **Rotation:** `req` = 3'b101 held → owners 0, 2, 0, 2 …, each for exactly 8 cycles, with a `slot_start` at each change.
- **Sole requester:** `req` = 3'b010 only → owner 1 re-granted every 8 cycles with a `slot_start` pulse. Dropping `req[1]` gives `blank` = 1 after 1 cycle.
- **Preemption:** `alert_req` = 1 for 1 cycle at cycle 3 of source 1's slot → the next cycle shows owner 3, 24'h999999, and `alert_ack` = 1; 4 alert cycles follow, then source 1 returns with a full 8-cycle dwell.
- **Held alert:** `alert_req` held for 10 cycles → alert displayed 10 cycles, not 4, then rotation resumes.
- **Live data:** change data2 from 24'h333333 to 24'h190905 mid-slot while source 2 owns the display → `data_out` = 24'h190905 one cycle later with no `slot_start`.

Source files
------------

// File: rtl/seg_display_arbiter.sv
// Time-shares a 6-digit BCD display among three round-robin sources and a
// preempting alert source; all outputs are registered from the next-state decision.
module seg_display_arbiter #(
    parameter int DWELL_CYC = 50_000_000,
    parameter int ALERT_MIN = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [23:0] data0,
    input  logic [23:0] data1,
    input  logic [23:0] data2,
    input  logic        alert_req,
    input  logic [23:0] alert_data,
    output logic        alert_ack,
    output logic [23:0] data_out,
    output logic        blank,
    output logic [1:0]  owner,
    output logic        slot_start
);
    localparam int DW = $clog2(DWELL_CYC);
    localparam int AW = (ALERT_MIN > 1) ? $clog2(ALERT_MIN) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(DWELL_CYC - 1);
    localparam logic [AW-1:0] A_LAST = AW'(ALERT_MIN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHOW  = 2'd1;
    localparam logic [1:0] S_ALERT = 2'd2;

    logic [1:0]    state;
    logic [DW-1:0] cnt;
    logic [AW-1:0] acnt;
    logic [1:0]    last;
    logic          intr_vld;

    // Returns {hit, idx}: first requester at base+1, base+2, base+3 (mod 3).
    function automatic logic [2:0] scan(input logic [2:0] r, input logic [1:0] base);
        logic [1:0] c;
        scan = 3'b000;
        c = base;
        for (int k = 0; k < 3; k++) begin
            c = (c == 2'd2) ? 2'd0 : c + 2'd1;
            if (!scan[2] && r[c])
                scan = {1'b1, c};
        end
    endfunction

    logic [2:0]  sc;
    logic        req_last;
    logic        to_alert, grant, go_idle;
    logic [1:0]  gidx;
    logic [1:0]  sel;
    logic [23:0] src;
    logic [23:0] nxt_data;

    assign sc = scan(req, last);

    // While showing, last equals the owner, so this doubles as the owner's request.
    always_comb begin
        case (last)
            2'd0:    req_last = req[0];
            2'd1:    req_last = req[1];
            2'd2:    req_last = req[2];
            default: req_last = 1'b0;
        endcase
    end

    always_comb begin
        to_alert = 1'b0;
        grant    = 1'b0;
        go_idle  = 1'b0;
        gidx     = sc[1:0];
        case (state)
            S_IDLE: begin
                if (alert_req)  to_alert = 1'b1;
                else if (sc[2]) grant    = 1'b1;
            end
            S_SHOW: begin
                if (alert_req) to_alert = 1'b1;
                else if (!req_last || cnt == D_LAST) begin
                    if (sc[2]) grant   = 1'b1;
                    else       go_idle = 1'b1;
                end
            end
            S_ALERT: begin
                if (acnt == A_LAST && !alert_req) begin
                    if (intr_vld && req_last) begin
                        grant = 1'b1;
                        gidx  = last;
                    end else if (sc[2]) grant   = 1'b1;
                    else                go_idle = 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase
    end

    always_comb begin
        sel = grant ? gidx : owner;
        case (sel)
            2'd0:    src = data0;
            2'd1:    src = data1;
            default: src = data2;
        endcase
        if (to_alert || (state == S_ALERT && !grant && !go_idle))
            nxt_data = alert_data;
        else if (go_idle || (state == S_IDLE && !grant))
            nxt_data = '0;
        else
            nxt_data = src;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            data_out   <= '0;
            blank      <= 1'b1;
            owner      <= 2'd0;
            alert_ack  <= 1'b0;
            slot_start <= 1'b0;
            cnt        <= '0;
            acnt       <= '0;
            last       <= 2'd2;
            intr_vld   <= 1'b0;
        end else begin
            alert_ack  <= 1'b0;
            slot_start <= 1'b0;
            data_out   <= nxt_data;
            if (to_alert) begin
                state      <= S_ALERT;
                owner      <= 2'd3;
                blank      <= 1'b0;
                acnt       <= '0;
                alert_ack  <= 1'b1;
                slot_start <= 1'b1;
                intr_vld   <= (state == S_SHOW);
            end else if (grant) begin
                state      <= S_SHOW;
                owner      <= gidx;
                last       <= gidx;
                blank      <= 1'b0;
                cnt        <= '0;
                slot_start <= 1'b1;
            end else if (go_idle) begin
                state <= S_IDLE;
                blank <= 1'b1;
            end else begin
                if (state == S_SHOW && cnt != D_LAST)
                    cnt <= cnt + 1'b1;
                if (state == S_ALERT && acnt != A_LAST)
                    acnt <= acnt + 1'b1;
            end
        end
    end
endmodule
